// File: rtl/lbr_unit_if.sv
// ---------------------------------------------------------------------------
// lbr_unit_if : bundle of the fetch-snoop and software-access signals of the
//               Last Branch Record unit.
//
//   stall        pipeline stall, blocks capture while high
//   lbrReq       software access: 0x none, 10 read, 11 write
//   next_PC_sel  fetch select: 00 PC+4, 01 branch, 10 JAL, 11 JALR
//   RW_address   register-window address
//   ALU_result   software write data
//   PC_address   PC of the current jump (record source)
//   JAL_target   JAL destination
//   JALR_target  JALR destination
//   output_data  registered software read data
//
// master: the core / software side driving the unit.
// slave : the lbr_unit itself.
// ---------------------------------------------------------------------------
interface lbr_unit_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDRESS_BITS = 12
);
  logic                    stall;
  logic [1:0]              lbrReq;
  logic [1:0]              next_PC_sel;
  logic [ADDRESS_BITS-1:0] RW_address;
  logic [DATA_WIDTH-1:0]   ALU_result;
  logic [ADDRESS_BITS-1:0] PC_address;
  logic [ADDRESS_BITS-1:0] JAL_target;
  logic [ADDRESS_BITS-1:0] JALR_target;
  logic [DATA_WIDTH-1:0]   output_data;

  modport master (
    output stall, lbrReq, next_PC_sel, RW_address, ALU_result,
           PC_address, JAL_target, JALR_target,
    input  output_data
  );

  modport slave (
    input  stall, lbrReq, next_PC_sel, RW_address, ALU_result,
           PC_address, JAL_target, JALR_target,
    output output_data
  );
endinterface

// File: rtl/lbr_unit.sv
// ---------------------------------------------------------------------------
// lbr_unit : Last Branch Record unit. Snoops the fetch next-PC select and
//            records every taken JAL/JALR as a (FROM, TO) pair in a circular
//            buffer of LBR_DEPTH entries. Software reads/writes the records
//            through a register window:
//              A <  2*LBR_DEPTH : entry A>>1, A[0] = 0 FROM / 1 TO
//              A == 2*LBR_DEPTH : TOS (next slot to fill), read-only
//              A == 2*LBR_DEPTH+1 : COUNT (valid entries), read-only
//              otherwise        : reads 0, writes ignored
//
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-high; clears buffer, TOS, COUNT, output_data
//   bus    lbr_unit_if.slave (snoop inputs, software access, output_data)
// ---------------------------------------------------------------------------
module lbr_unit #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDRESS_BITS = 12,
  parameter int LBR_DEPTH    = 8
) (
  input  logic       clock,
  input  logic       reset,
  lbr_unit_if.slave  bus
);

  localparam int PTR_W = $clog2(LBR_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ADDRESS_BITS-1:0] TOS_ADDR   = ADDRESS_BITS'(2 * LBR_DEPTH);
  localparam logic [ADDRESS_BITS-1:0] COUNT_ADDR = ADDRESS_BITS'(2 * LBR_DEPTH + 1);
  localparam logic [CNT_W-1:0]        COUNT_MAX  = CNT_W'(LBR_DEPTH);

  logic [ADDRESS_BITS-1:0] from_q [LBR_DEPTH];
  logic [ADDRESS_BITS-1:0] to_q   [LBR_DEPTH];
  logic [PTR_W-1:0]        tos_q;
  logic [CNT_W-1:0]        count_q;

  logic                    capture;
  logic [ADDRESS_BITS-1:0] cap_to;
  logic                    sw_rd;
  logic                    sw_wr;
  logic                    win_entry;
  logic [PTR_W-1:0]        win_idx;
  logic [ADDRESS_BITS-1:0] rd_val;
  logic [ADDRESS_BITS-1:0] wr_val;

  // Only JAL (10) and JALR (11) are recorded; select bit 0 picks the target.
  assign capture   = !bus.stall && bus.next_PC_sel[1];
  assign cap_to    = bus.next_PC_sel[0] ? bus.JALR_target : bus.JAL_target;

  assign sw_rd     = (bus.lbrReq == 2'b10);
  assign sw_wr     = (bus.lbrReq == 2'b11);
  assign win_entry = (bus.RW_address < TOS_ADDR);
  assign win_idx   = bus.RW_address[PTR_W:1];
  assign wr_val    = ADDRESS_BITS'(bus.ALU_result);

  // Read mux works on the registered (pre-capture) contents, so a read of the
  // slot being captured in the same cycle returns the old record.
  always_comb begin
    rd_val = '0;
    if (win_entry)
      rd_val = bus.RW_address[0] ? to_q[win_idx] : from_q[win_idx];
    else if (bus.RW_address == TOS_ADDR)
      rd_val = ADDRESS_BITS'(tos_q);
    else if (bus.RW_address == COUNT_ADDR)
      rd_val = ADDRESS_BITS'(count_q);
  end

  // Record storage.
  // NOTE: the buffer is cleared by reset because software may read any entry
  // straight out of reset and must see zeros; it therefore cannot map onto a
  // plain RAM macro.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LBR_DEPTH; i++) begin
        from_q[i] <= '0;
        to_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < LBR_DEPTH; i++) begin
        if (capture && tos_q == PTR_W'(i)) begin
          from_q[i] <= bus.PC_address;
          to_q[i]   <= cap_to;
        end
        // NOTE: the software write is placed after the capture so that, for
        // the same field in the same cycle, the last non-blocking assignment
        // wins; different fields are untouched by each other.
        if (sw_wr && win_entry && win_idx == PTR_W'(i)) begin
          if (bus.RW_address[0]) to_q[i]   <= wr_val;
          else                   from_q[i] <= wr_val;
        end
      end
    end
  end

  // TOS wraps naturally at LBR_DEPTH (power of two); COUNT saturates.
  // NOTE: all state registers use non-blocking assignments so every process
  // sees the pre-edge values regardless of evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tos_q   <= '0;
      count_q <= '0;
    end else if (capture) begin
      tos_q <= tos_q + 1'b1;
      if (count_q != COUNT_MAX) count_q <= count_q + 1'b1;
    end
  end

  // Read data register; holds on writes and idle cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      bus.output_data <= '0;
    else if (sw_rd) bus.output_data <= DATA_WIDTH'(rd_val);
  end

endmodule

// File: tb/tb_lbr_unit.sv
// ---------------------------------------------------------------------------
// tb_lbr_unit : directed bench for lbr_unit. A history-based model (total
// capture count, slot = captures mod depth) predicts output_data every cycle;
// hand-computed literals pin the model on the key scenarios.
// ---------------------------------------------------------------------------
module tb_lbr_unit;

  localparam int DW    = 16;
  localparam int AB    = 12;
  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  lbr_unit_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB)) bus ();

  lbr_unit #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .LBR_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- model ----------------
  logic [AB-1:0] m_from [DEPTH];
  logic [AB-1:0] m_to   [DEPTH];
  int            m_total;        // captures since reset
  logic [DW-1:0] m_out;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_from[i] = '0;
      m_to[i]   = '0;
    end
    m_total = 0;
    m_out   = '0;
  endtask

  function automatic logic [DW-1:0] model_read(input int a);
    int v;
    v = 0;
    if (a < 2 * DEPTH)       v = (a % 2 == 1) ? int'(m_to[a / 2]) : int'(m_from[a / 2]);
    else if (a == 2 * DEPTH) v = m_total % DEPTH;
    else if (a == 2 * DEPTH + 1) v = (m_total < DEPTH) ? m_total : DEPTH;
    return DW'(v);
  endfunction

  // Effect of one rising edge given the inputs that were sampled on it.
  task automatic model_edge(input logic st, input logic [1:0] req,
                            input logic [1:0] sel, input int a,
                            input logic [DW-1:0] alu, input logic [AB-1:0] pc,
                            input logic [AB-1:0] jt, input logic [AB-1:0] jrt);
    int slot;
    if (req == 2'b10) m_out = model_read(a);
    if (!st && (sel == 2'b10 || sel == 2'b11)) begin
      slot         = m_total % DEPTH;
      m_from[slot] = pc;
      m_to[slot]   = (sel == 2'b11) ? jrt : jt;
      m_total      = m_total + 1;
    end
    if (req == 2'b11 && a < 2 * DEPTH) begin
      if (a % 2 == 1) m_to[a / 2]   = alu[AB-1:0];
      else            m_from[a / 2] = alu[AB-1:0];
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) check("out_vs_model", bus.output_data, m_out);

  // ---------------- stimulus ----------------
  task automatic step(input logic st, input logic [1:0] req, input logic [1:0] sel,
                      input int a, input logic [DW-1:0] alu, input logic [AB-1:0] pc,
                      input logic [AB-1:0] jt, input logic [AB-1:0] jrt);
    bus.stall       = st;
    bus.lbrReq      = req;
    bus.next_PC_sel = sel;
    bus.RW_address  = AB'(a);
    bus.ALU_result  = alu;
    bus.PC_address  = pc;
    bus.JAL_target  = jt;
    bus.JALR_target = jrt;
    @(posedge clock);
    model_edge(st, req, sel, a, alu, pc, jt, jrt);
    #1;
    bus.lbrReq      = 2'b00;
    bus.next_PC_sel = 2'b00;
  endtask

  task automatic rd(input int a, input logic [DW-1:0] exp, input string name);
    step(1'b0, 2'b10, 2'b00, a, '0, '0, '0, '0);
    check(name, bus.output_data, exp);
  endtask

  logic [DW-1:0] exp_fill [18] = '{
    16'h0000, 16'h0FFF, 16'h0001, 16'h0002, 16'h0002, 16'h03FF,
    16'h0004, 16'h00FF, 16'h0005, 16'h0020, 16'h0006, 16'h003F,
    16'h0007, 16'h0080, 16'h0000, 16'h0000, 16'h0007, 16'h0007
  };

  initial begin
    logic [AB-1:0] ones;
    ones = 12'hFFF;
    model_clear();
    bus.stall = 1'b0; bus.lbrReq = 2'b00; bus.next_PC_sel = 2'b00;
    bus.RW_address = '0; bus.ALU_result = '0; bus.PC_address = '0;
    bus.JAL_target = '0; bus.JALR_target = '0;
    #1 check("reset_out", bus.output_data, 16'h0000);
    #11 reset = 1'b0;

    // Empty buffer: whole window reads zero.
    for (int a = 0; a < 32; a++) rd(a, 16'h0000, "empty_window");

    // Eight jumps, alternating JALR/JAL, one stalled.
    for (int i = 0; i < 8; i++)
      step(i == 3, 2'b00, (i % 2 == 0) ? 2'b11 : 2'b10, 0, '0,
           AB'(i), AB'(1) << i, ones >> i);
    for (int a = 0; a < 18; a++) rd(a, exp_fill[a], "fill_read");

    // Software write to entry 3 TO, truncated to record width.
    step(1'b0, 2'b11, 2'b00, 7, 16'hAAAA, '0, '0, '0);
    rd(7,  16'h0AAA, "sw_write");
    rd(6,  16'h0004, "sw_write_neighbour");
    rd(16, 16'h0007, "tos_after_write");
    rd(17, 16'h0007, "count_after_write");

    // Non-jump selects and stalled jumps record nothing.
    step(1'b0, 2'b00, 2'b00, 0, '0, 12'h111, 12'h222, 12'h333);
    step(1'b0, 2'b00, 2'b01, 0, '0, 12'h111, 12'h222, 12'h333);
    step(1'b1, 2'b00, 2'b10, 0, '0, 12'h111, 12'h222, 12'h333);
    step(1'b1, 2'b10, 2'b11, 1, '0, 12'h111, 12'h222, 12'h333);
    check("read_during_stall", bus.output_data, 16'h0FFF);
    rd(16, 16'h0007, "tos_no_capture");
    rd(17, 16'h0007, "count_no_capture");
    rd(14, 16'h0000, "entry7_empty");

    // Capture into entry 7 while software writes its TO field: write wins.
    step(1'b0, 2'b11, 2'b10, 15, 16'h0123, 12'h077, 12'h555, 12'h666);
    rd(14, 16'h0077, "conflict_from");
    rd(15, 16'h0123, "conflict_to");
    rd(16, 16'h0000, "tos_wrapped");
    rd(17, 16'h0008, "count_full");

    // Read of entry 0 while it is being overwritten returns the old record.
    step(1'b0, 2'b10, 2'b10, 0, '0, 12'h099, 12'h0AA, 12'h0BB);
    check("read_precapture", bus.output_data, 16'h0000);
    rd(0, 16'h0099, "post_capture");

    // Reset lands between a read request and its result.
    bus.lbrReq = 2'b10; bus.RW_address = 12'd15;
    #2 reset = 1'b1;
    model_clear();
    #1 check("async_reset_out", bus.output_data, 16'h0000);
    @(posedge clock);
    #1 reset = 1'b0;
    bus.lbrReq = 2'b00;
    check("reset_holds_out", bus.output_data, 16'h0000);
    rd(15, 16'h0000, "cleared_entry");
    rd(16, 16'h0000, "cleared_tos");
    rd(17, 16'h0000, "cleared_count");

    // Ten JALs wrap the buffer.
    for (int k = 0; k < 10; k++)
      step(1'b0, 2'b00, 2'b10, 0, '0, AB'(12'h100 + k), AB'(12'h200 + k), 12'hFFF);
    rd(0,  16'h0108, "wrap_e0_from");
    rd(1,  16'h0208, "wrap_e0_to");
    rd(2,  16'h0109, "wrap_e1_from");
    rd(3,  16'h0209, "wrap_e1_to");
    rd(4,  16'h0102, "wrap_e2_from");
    rd(16, 16'h0002, "wrap_tos");
    rd(17, 16'h0008, "wrap_count");

    repeat (2) @(posedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lbr_unit.md
# lbr_unit

Last Branch Record (LBR) unit for the BRISC-V core. It passively snoops the fetch stage's next-PC selection and captures every taken jump (JAL/JALR) as a (source PC, target) pair in a circular buffer of `LBR_DEPTH` entries. Software reads or overwrites records through a small register window addressed by `RW_address`; `lbrReq` steers each access. The unit sits beside the fetch/execute stages and does not alter control flow.

## Interface
- `DATA_WIDTH`, default 16: width of the software data path (`ALU_result`, `output_data`).
- `ADDRESS_BITS`, default 12: width of PCs, targets and the stored record fields.
- `LBR_DEPTH`, default 8: number of records; must be a power of two, at most 2^(ADDRESS_BITS-2).
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `stall`  in  1  pipeline stall; while high, no record is captured.
- `lbrReq`  in  2  software access: 00/01 none, 10 read, 11 write.
- `next_PC_sel`  in  2  fetch select: 00 PC+4, 01 branch, 10 JAL, 11 JALR.
- `RW_address`  in  ADDRESS_BITS  register-window address for software access.
- `ALU_result`  in  DATA_WIDTH  software write data.
- `PC_address`  in  ADDRESS_BITS  PC of the current jump (record source).
- `JAL_target`  in  ADDRESS_BITS  JAL destination.
- `JALR_target`  in  ADDRESS_BITS  JALR destination.
- `output_data`  out  DATA_WIDTH  registered software read data.

## Operation
- Storage: `LBR_DEPTH` entries, each holding FROM and TO fields of `ADDRESS_BITS`; a TOS pointer (next slot to fill, log2(LBR_DEPTH) bits); a COUNT of valid entries (0..LBR_DEPTH, saturating).
- Capture condition: `stall`==0 and `next_PC_sel`==10 or 11. On capture:
  - FROM = `PC_address`.
  - TO = `JAL_target` for 10, `JALR_target` for 11.
  - Both fields written into entry TOS; TOS increments modulo `LBR_DEPTH`; COUNT increments and saturates at `LBR_DEPTH`.
- Selects 00 and 01 are never recorded.
- Wrap-around: the record after entry `LBR_DEPTH`-1 goes to entry 0, overwriting the oldest entry; COUNT stays at `LBR_DEPTH`.
- Register window (address A = `RW_address`):
  - A < 2*`LBR_DEPTH`: entry A>>1; bit 0 selects FROM (0) or TO (1).
  - A == 2*`LBR_DEPTH`: TOS, read-only.
  - A == 2*`LBR_DEPTH`+1: COUNT, read-only.
  - All other addresses read 0; writes to them are ignored.
- Read (`lbrReq`==10): `output_data` is loaded with the selected value, zero-extended to `DATA_WIDTH`.
- Write (`lbrReq`==11): the selected entry field is loaded with `ALU_result[ADDRESS_BITS-1:0]`; TOS and COUNT are unchanged; `output_data` holds.
- No access (`lbrReq[1]`==0): `output_data` holds its previous value.
- `stall` gates capture only; software accesses proceed during stall.
- Same-cycle capture and software write to the same entry field: the software write wins. If they target different fields, both take effect.
- Same-cycle capture and read of the entry being captured: the read returns the pre-capture contents.

## Timing
- Reset (asynchronous, any time, including mid-access): all entries 0, TOS 0, COUNT 0, `output_data` 0. Every output is 0 out of reset.
- Capture: inputs are sampled at the rising edge. The record is visible to a read issued on the next cycle.
- Read latency: one cycle. The value sampled at edge N appears on `output_data` after edge N and holds until the next read or reset.
- Write: takes effect at the sampling edge. A read in the following cycle returns the new value.
- No handshake; one access per cycle.

## Test plan
- Reset then read every window address 0..31 -> `output_data` 0x0000 for all; TOS 0; COUNT 0.
- For i=0..7 drive PC=i, JAL_target=1<<i, JALR_target=0xFFF>>i, sel = 11 for even i and 10 for odd i, with stall=1 only at i=3. Then read addresses 0..17 -> 0x0000, 0x0FFF, 0x0001, 0x0002, 0x0002, 0x03FF, 0x0004, 0x00FF, 0x0005, 0x0020, 0x0006, 0x003F, 0x0007, 0x0080, 0, 0, TOS=7, COUNT=7.
- Write 0xAAAA to address 7, then read address 7 -> 0x0AAA; address 6 still 0x0004; TOS/COUNT unchanged.
- Capture 10 JALs with PC=0x100+k -> entries 0..1 hold k=8,9; entry 2 FROM=0x102; TOS=2; COUNT=8.
- Capture with next_PC_sel 00/01, or with stall=1 -> no entry, TOS or COUNT change; a read during stall still returns data.
- Assert reset between a read request and its result -> `output_data` 0 immediately; buffer cleared.
